// File: rtl/ldst_pkg.sv
// Shared encodings for the EXE-stage load/store request issuer:
// access sizes, issuer FSM states and byte-strobe patterns.
package ldst_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SENT = 2'd2
  } ldst_state_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_HLO  = 4'b0011;
  localparam logic [3:0] STRB_HHI  = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/ldst_fmt.sv
// Combinational formatter: misalignment detect, byte strobes and
// replicated write data for a load/store of the given size.
module ldst_fmt
  import ldst_pkg::*;
(
  input  logic        op_store,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  // Decode size into alignment check, lane strobes and lane-replicated data.
  always_comb begin
    misalign = 1'b0;
    wstrb    = STRB_NONE;
    wdata    = st_data;
    case (size)
      SZ_B: begin
        wstrb = STRB_B0 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        misalign = addr_lo[0];
        wstrb    = addr_lo[1] ? STRB_HHI : STRB_HLO;
        wdata    = {2{st_data[15:0]}};
      end
      SZ_W: begin
        misalign = |addr_lo;
        wstrb    = STRB_W;
      end
      default: ;
    endcase
    // Loads never write any byte lane.
    if (!op_store) wstrb = STRB_NONE;
  end

endmodule

// File: rtl/exe_ldst_req.sv
// EXE-stage load/store request issuer. Checks alignment, drives the data
// SRAM-like request channel (holding req until addr_ok), produces EXE
// ready_go / MEM cancel flags, and counts accepted-but-cancelled requests so
// their data_ok can be discarded.
// Optional wait-cycle counter: define EXE_LDST_PERF_EN.
module exe_ldst_req
  import ldst_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic [31:0] vaddr,
  input  logic [31:0] st_data,
  input  logic        exc_in,
  input  logic        flush,
  input  logic        mem_cancel,
  input  logic        out_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        ready_go,
  output logic        ale,
  output logic        ls_cancel,
  output logic        req_sent,
  output logic        resp_discard,
  output logic [31:0] perf_wait_cyc
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

  ldst_state_e   state_q, state_d;
  logic          flushed_q, flushed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic        need, blk, issue, cancel_acc, cnt_dec;
  logic        fmt_misalign;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;

  ldst_fmt u_fmt (
    .op_store (op_store),
    .size     (op_size),
    .addr_lo  (vaddr[1:0]),
    .st_data  (st_data),
    .misalign (fmt_misalign),
    .wstrb    (fmt_wstrb),
    .wdata    (fmt_wdata)
  );

  assign need  = in_valid & (op_load | op_store);
  assign ale   = need & fmt_misalign;
  assign blk   = exc_in | ale | flush | mem_cancel;
  assign issue = need & ~blk;

  // Next-state and channel/pipeline outputs; REQ replays the captured request
  // so the channel stays stable even if EXE is flushed underneath it.
  always_comb begin
    state_d         = state_q;
    flushed_d       = flushed_q;
    cancel_acc      = 1'b0;
    data_sram_req   = 1'b0;
    ready_go        = ~need;
    ls_cancel       = 1'b0;
    req_sent        = 1'b0;
    data_sram_wr    = op_store;
    data_sram_size  = op_size;
    data_sram_wstrb = fmt_wstrb;
    data_sram_addr  = vaddr;
    data_sram_wdata = fmt_wdata;
    case (state_q)
      IDLE: begin
        data_sram_req = issue;
        if (need && blk) begin
          ls_cancel = 1'b1;
          ready_go  = 1'b1;
        end
        if (issue && data_sram_addr_ok) begin
          ready_go = 1'b1;
          state_d  = SENT;
        end else if (issue) begin
          state_d   = REQ;
          flushed_d = 1'b0;
        end
      end
      REQ: begin
        data_sram_req   = 1'b1;
        data_sram_wr    = wr_q;
        data_sram_size  = size_q;
        data_sram_wstrb = strb_q;
        data_sram_addr  = addr_q;
        data_sram_wdata = wdata_q;
        if (flush) flushed_d = 1'b1;
        if (data_sram_addr_ok) begin
          flushed_d = 1'b0;
          if (flush || flushed_q) begin
            state_d    = IDLE;
            cancel_acc = 1'b1;
          end else begin
            state_d = SENT;
          end
        end
      end
      SENT: begin
        ready_go = 1'b1;
        req_sent = 1'b1;
        if (flush) begin
          state_d    = IDLE;
          cancel_acc = 1'b1;
        end else if (out_allowin) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request fields on the cycle a request first goes out.
  always_comb begin
    wr_d    = wr_q;
    size_d  = size_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && issue) begin
      wr_d    = op_store;
      size_d  = op_size;
      strb_d  = fmt_wstrb;
      addr_d  = vaddr;
      wdata_d = fmt_wdata;
    end
  end

  // Discard counter: +1 per cancelled accept, -1 per discarded data_ok.
  assign cnt_dec      = data_sram_data_ok & (cnt_q != '0);
  assign resp_discard = cnt_dec;

  always_comb begin
    cnt_d = cnt_q;
    if (cancel_acc && !cnt_dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (cnt_dec && !cancel_acc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      flushed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      cnt_q     <= cnt_d;
    end
  end

  // Request payload register (no reset; only read while in REQ).
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    size_q  <= size_d;
    strb_q  <= strb_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // More cancelled requests in flight than MAX_OUTST means responses are lost.
  a_cnt_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
    !(cancel_acc && !cnt_dec && cnt_q == CNT_MAX));

`ifdef EXE_LDST_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Count cycles a held request waits for addr_ok.
  always_comb begin
    perf_d = perf_q;
    if (state_q == REQ && !data_sram_addr_ok) perf_d = perf_q + 32'd1;
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk) begin
    if (!resetn) perf_q <= 32'd0;
    else         perf_q <= perf_d;
  end

  assign perf_wait_cyc = perf_q;
`else
  assign perf_wait_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_exe_ldst_req.sv
// Self-checking bench for exe_ldst_req: directed scenarios plus randomized
// formatting/blocking checks against a small arithmetic reference model.
module tb_exe_ldst_req;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, op_load = 1'b0, op_store = 1'b0;
  logic [1:0]  op_size = 2'd0;
  logic [31:0] vaddr = 32'd0, st_data = 32'd0;
  logic        exc_in = 1'b0, flush = 1'b0, mem_cancel = 1'b0, out_allowin = 1'b1;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic        ready_go, ale, ls_cancel, req_sent, resp_discard;
  logic [31:0] perf_wait_cyc;

  int pass_cnt = 0;
  int total_cnt = 0;
  int perf_exp = 0;
  int disc_exp = 0;

`ifdef EXE_LDST_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  exe_ldst_req #(.MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .op_load(op_load),
    .op_store(op_store), .op_size(op_size), .vaddr(vaddr), .st_data(st_data),
    .exc_in(exc_in), .flush(flush), .mem_cancel(mem_cancel),
    .out_allowin(out_allowin), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .ready_go(ready_go), .ale(ale),
    .ls_cancel(ls_cancel), .req_sent(req_sent), .resp_discard(resp_discard),
    .perf_wait_cyc(perf_wait_cyc)
  );

  // Reference model: access width in bytes, alignment, strobes, data.
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit m_ale(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit st, input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    n = nbytes(sz);
    off = int'(a % 4);
    off = off - (off % n);
    if (!st) return 4'b0000;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (nbytes(sz))
      1:       return {24'd0, d[7:0]} * 32'h01010101;
      2:       return {16'd0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic clr_in();
    in_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_size = 2'd0;
    vaddr = 32'd0; st_data = 32'd0; exc_in = 1'b0; flush = 1'b0;
    mem_cancel = 1'b0; out_allowin = 1'b1; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic drive_op(input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; op_store = st; op_load = ~st; op_size = sz; vaddr = a; st_data = d;
  endtask

  task automatic test_reset();
    clr_in();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    #1;
    total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL reset_req got %b want 0", data_sram_req); else pass_cnt++;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL reset_req_sent got %b want 0", req_sent); else pass_cnt++;
    total_cnt++; if (ready_go !== 1'b1) $display("FAIL reset_ready_go got %b want 1", ready_go); else pass_cnt++;
    total_cnt++; if (ls_cancel !== 1'b0) $display("FAIL reset_ls_cancel got %b want 0", ls_cancel); else pass_cnt++;
    total_cnt++; if (resp_discard !== 1'b0) $display("FAIL reset_discard got %b want 0", resp_discard); else pass_cnt++;
    total_cnt++; if (perf_wait_cyc !== 32'd0) $display("FAIL reset_perf got %0d want 0", perf_wait_cyc); else pass_cnt++;
    @(negedge clk); clr_in();
  endtask

  task automatic test_store_byte();
    drive_op(1'b1, 2'd0, 32'h1003, 32'h000000A5);
    data_sram_addr_ok = 1'b1;
    #1;
    total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL stb_req got %b want 1", data_sram_req); else pass_cnt++;
    total_cnt++; if (data_sram_wr !== 1'b1) $display("FAIL stb_wr got %b want 1", data_sram_wr); else pass_cnt++;
    total_cnt++; if (data_sram_size !== 2'd0) $display("FAIL stb_size got %0d want 0", data_sram_size); else pass_cnt++;
    total_cnt++; if (data_sram_wstrb !== 4'b1000) $display("FAIL stb_wstrb got %b want 1000", data_sram_wstrb); else pass_cnt++;
    total_cnt++; if (data_sram_wdata !== 32'hA5A5A5A5) $display("FAIL stb_wdata got %h want a5a5a5a5", data_sram_wdata); else pass_cnt++;
    total_cnt++; if (data_sram_addr !== 32'h1003) $display("FAIL stb_addr got %h want 1003", data_sram_addr); else pass_cnt++;
    total_cnt++; if (ready_go !== 1'b1) $display("FAIL stb_ready_go got %b want 1", ready_go); else pass_cnt++;
    @(negedge clk); clr_in(); #1;
    total_cnt++; if (req_sent !== 1'b1) $display("FAIL stb_sent got %b want 1", req_sent); else pass_cnt++;
    total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL stb_one_req got %b want 0", data_sram_req); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL stb_idle got %b want 0", req_sent); else pass_cnt++;
  endtask

  task automatic test_ale();
    drive_op(1'b0, 2'd2, 32'h1002, 32'd0);
    data_sram_addr_ok = 1'b1;
    #1;
    total_cnt++; if (ale !== 1'b1) $display("FAIL ale_flag got %b want 1", ale); else pass_cnt++;
    total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL ale_req got %b want 0", data_sram_req); else pass_cnt++;
    total_cnt++; if (ls_cancel !== 1'b1) $display("FAIL ale_cancel got %b want 1", ls_cancel); else pass_cnt++;
    total_cnt++; if (ready_go !== 1'b1) $display("FAIL ale_ready_go got %b want 1", ready_go); else pass_cnt++;
    @(negedge clk); clr_in(); #1;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL ale_no_sent got %b want 0", req_sent); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_mem_cancel();
    drive_op(1'b1, 2'd2, 32'h0000_4000, $urandom);
    mem_cancel = 1'b1;
    data_sram_addr_ok = 1'b1;
    #1;
    total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL mc_req got %b want 0", data_sram_req); else pass_cnt++;
    total_cnt++; if (ls_cancel !== 1'b1) $display("FAIL mc_cancel got %b want 1", ls_cancel); else pass_cnt++;
    total_cnt++; if (ready_go !== 1'b1) $display("FAIL mc_ready_go got %b want 1", ready_go); else pass_cnt++;
    @(negedge clk); clr_in(); #1;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL mc_no_sent got %b want 0", req_sent); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wait();
    for (int r = 0; r < 3; r++) begin
      logic [1:0]  sz;
      logic [31:0] a, d;
      bit          st;
      int          nw;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & ~32'(nbytes(sz) - 1);
      d  = $urandom;
      st = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      drive_op(st, sz, a, d);
      #1;
      total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL wait_req0 got %b want 1", data_sram_req); else pass_cnt++;
      total_cnt++; if (ready_go !== 1'b0) $display("FAIL wait_rg0 got %b want 0", ready_go); else pass_cnt++;
      for (int i = 0; i < nw; i++) begin
        @(negedge clk); #1;
        perf_exp++;
        total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL wait_req_hold got %b want 1", data_sram_req); else pass_cnt++;
        total_cnt++; if (data_sram_addr !== a) $display("FAIL wait_addr got %h want %h", data_sram_addr, a); else pass_cnt++;
        total_cnt++; if (data_sram_wstrb !== m_strb(st, sz, a)) $display("FAIL wait_wstrb got %b want %b", data_sram_wstrb, m_strb(st, sz, a)); else pass_cnt++;
        total_cnt++; if (ready_go !== 1'b0) $display("FAIL wait_rg got %b want 0", ready_go); else pass_cnt++;
      end
      @(negedge clk); data_sram_addr_ok = 1'b1; #1;
      total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL wait_req_acc got %b want 1", data_sram_req); else pass_cnt++;
      if (st) begin
        total_cnt++; if (data_sram_wdata !== m_wdata(sz, d)) $display("FAIL wait_wdata got %h want %h", data_sram_wdata, m_wdata(sz, d)); else pass_cnt++;
      end
      @(negedge clk); data_sram_addr_ok = 1'b0; #1;
      total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL wait_req_done got %b want 0", data_sram_req); else pass_cnt++;
      total_cnt++; if (req_sent !== 1'b1 || ready_go !== 1'b1) $display("FAIL wait_sent got %b%b want 11", req_sent, ready_go); else pass_cnt++;
      total_cnt++; if (perf_wait_cyc !== (PERF_ON ? 32'(perf_exp) : 32'd0)) $display("FAIL wait_perf got %0d want %0d", perf_wait_cyc, PERF_ON ? perf_exp : 0); else pass_cnt++;
      @(negedge clk); clr_in(); #1;
      total_cnt++; if (req_sent !== 1'b0) $display("FAIL wait_idle got %b want 0", req_sent); else pass_cnt++;
    end
  endtask

  task automatic test_sent_hold();
    logic [31:0] d;
    d = $urandom;
    drive_op(1'b1, 2'd1, 32'h3002, d);
    data_sram_addr_ok = 1'b1; out_allowin = 1'b0;
    #1;
    total_cnt++; if (data_sram_wstrb !== 4'b1100) $display("FAIL hold_wstrb got %b want 1100", data_sram_wstrb); else pass_cnt++;
    total_cnt++; if (data_sram_wdata !== m_wdata(2'd1, d)) $display("FAIL hold_wdata got %h want %h", data_sram_wdata, m_wdata(2'd1, d)); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); data_sram_addr_ok = 1'b1; #1;
      total_cnt++; if (req_sent !== 1'b1) $display("FAIL hold_sent got %b want 1", req_sent); else pass_cnt++;
      total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL hold_no_req got %b want 0", data_sram_req); else pass_cnt++;
    end
    @(negedge clk); out_allowin = 1'b1; data_sram_addr_ok = 1'b0; #1;
    total_cnt++; if (req_sent !== 1'b1) $display("FAIL hold_last got %b want 1", req_sent); else pass_cnt++;
    @(negedge clk); clr_in(); #1;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL hold_idle got %b want 0", req_sent); else pass_cnt++;
  endtask

  task automatic test_flush_req();
    logic [31:0] a;
    a = $urandom & ~32'h3;
    drive_op(1'b0, 2'd2, a, 32'd0);
    #1;
    @(negedge clk); flush = 1'b1; #1;
    perf_exp++;
    total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL flr_req_flush got %b want 1", data_sram_req); else pass_cnt++;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; vaddr = ~a; #1;
    perf_exp++;
    total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL flr_req_after got %b want 1", data_sram_req); else pass_cnt++;
    total_cnt++; if (data_sram_addr !== a) $display("FAIL flr_addr got %h want %h", data_sram_addr, a); else pass_cnt++;
    @(negedge clk); data_sram_addr_ok = 1'b1; #1;
    total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL flr_req_acc got %b want 1", data_sram_req); else pass_cnt++;
    @(negedge clk); data_sram_addr_ok = 1'b0; #1;
    disc_exp++;
    total_cnt++; if (data_sram_req !== 1'b0 || req_sent !== 1'b0) $display("FAIL flr_idle got %b%b want 00", data_sram_req, req_sent); else pass_cnt++;
    total_cnt++; if (perf_wait_cyc !== (PERF_ON ? 32'(perf_exp) : 32'd0)) $display("FAIL flr_perf got %0d want %0d", perf_wait_cyc, PERF_ON ? perf_exp : 0); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); data_sram_data_ok = 1'b1; #1;
      total_cnt++; if (resp_discard !== (disc_exp > 0)) $display("FAIL flr_discard%0d got %b want %b", i, resp_discard, disc_exp > 0); else pass_cnt++;
      if (disc_exp > 0) disc_exp--;
    end
    @(negedge clk); clr_in();
  endtask

  task automatic test_flush_sent();
    for (int k = 0; k < 3; k++) begin
      drive_op(k[0], 2'd2, 32'h0000_8000 + 32'(k * 4), $urandom);
      data_sram_addr_ok = 1'b1;
      @(negedge clk); data_sram_addr_ok = 1'b0; flush = 1'b1; out_allowin = 1'b0;
      data_sram_data_ok = (k == 2);
      #1;
      total_cnt++; if (req_sent !== 1'b1) $display("FAIL fls_sent%0d got %b want 1", k, req_sent); else pass_cnt++;
      total_cnt++; if (resp_discard !== (data_sram_data_ok && disc_exp > 0)) $display("FAIL fls_disc%0d got %b want %b", k, resp_discard, data_sram_data_ok && disc_exp > 0); else pass_cnt++;
      disc_exp = disc_exp + 1 - ((data_sram_data_ok && disc_exp > 0) ? 1 : 0);
      @(negedge clk); clr_in();
    end
    for (int i = 0; i < 3; i++) begin
      data_sram_data_ok = 1'b1; #1;
      total_cnt++; if (resp_discard !== (disc_exp > 0)) $display("FAIL fls_drain%0d got %b want %b", i, resp_discard, disc_exp > 0); else pass_cnt++;
      if (disc_exp > 0) disc_exp--;
      @(negedge clk);
    end
    clr_in();
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      logic [1:0]  sz;
      logic [31:0] a, d;
      bit          st, ex, mc, bl;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      d  = $urandom;
      st = 1'($urandom_range(0, 1));
      ex = ($urandom_range(0, 3) == 0);
      mc = ($urandom_range(0, 7) == 0);
      drive_op(st, sz, a, d);
      exc_in = ex; mem_cancel = mc; data_sram_addr_ok = 1'b1;
      bl = ex | mc | m_ale(sz, a);
      #1;
      total_cnt++; if (ale !== m_ale(sz, a)) $display("FAIL rnd_ale got %b want %b addr %h sz %0d", ale, m_ale(sz, a), a, sz); else pass_cnt++;
      total_cnt++; if (data_sram_req !== !bl) $display("FAIL rnd_req got %b want %b", data_sram_req, !bl); else pass_cnt++;
      total_cnt++; if (ls_cancel !== bl) $display("FAIL rnd_cancel got %b want %b", ls_cancel, bl); else pass_cnt++;
      total_cnt++; if (ready_go !== 1'b1) $display("FAIL rnd_ready_go got %b want 1", ready_go); else pass_cnt++;
      if (!bl) begin
        total_cnt++; if (data_sram_wr !== st) $display("FAIL rnd_wr got %b want %b", data_sram_wr, st); else pass_cnt++;
        total_cnt++; if (data_sram_wstrb !== m_strb(st, sz, a)) $display("FAIL rnd_wstrb got %b want %b", data_sram_wstrb, m_strb(st, sz, a)); else pass_cnt++;
        if (st) begin
          total_cnt++; if (data_sram_wdata !== m_wdata(sz, d)) $display("FAIL rnd_wdata got %h want %h", data_sram_wdata, m_wdata(sz, d)); else pass_cnt++;
        end
      end
      @(negedge clk); clr_in(); #1;
      total_cnt++; if (req_sent !== !bl) $display("FAIL rnd_sent got %b want %b", req_sent, !bl); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_req();
    drive_op(1'b0, 2'd2, 32'h0000_C000, 32'd0);
    @(negedge clk); #1;
    total_cnt++; if (data_sram_req !== 1'b1) $display("FAIL rst_req_held got %b want 1", data_sram_req); else pass_cnt++;
    resetn = 1'b0; in_valid = 1'b0; op_load = 1'b0;
    @(negedge clk); resetn = 1'b1; #1;
    perf_exp = 0;
    total_cnt++; if (data_sram_req !== 1'b0) $display("FAIL rst_req_drop got %b want 0", data_sram_req); else pass_cnt++;
    total_cnt++; if (req_sent !== 1'b0) $display("FAIL rst_sent got %b want 0", req_sent); else pass_cnt++;
    total_cnt++; if (perf_wait_cyc !== 32'(perf_exp)) $display("FAIL rst_perf got %0d want %0d", perf_wait_cyc, perf_exp); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_ale();
    test_mem_cancel();
    test_wait();
    test_sent_hold();
    test_flush_req();
    test_flush_sent();
    test_random();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
